// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port DMEM between the pipeline MEM stage
// (core) and a debug/loader port (dbg). Core has priority; a 4-bit starvation
// counter forces a dbg grant after STARVE_LIMIT consecutive core grants while
// dbg is waiting. Read data returns one cycle after the grant and is steered
// to the requester recorded in a registered response-owner state.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   core_req/we/addr/wdata          core request (MEM stage)
//   core_gnt, core_stall            core issued this cycle / core held off
//   core_rvalid, core_rdata         core read response
//   dbg_req/we/addr/wdata           debug request
//   dbg_gnt, dbg_rvalid, dbg_rdata  debug grant and read response
//   dmem_wr_en/addr/wr_data         DMEM command (combinational, grant cycle)
//   dmem_rd_data                    DMEM read data, one cycle after address
module dmem_arbiter #(
  parameter int unsigned REG_WIDTH    = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 core_req,
  input  logic                 core_we,
  input  logic [REG_WIDTH-1:0] core_addr,
  input  logic [REG_WIDTH-1:0] core_wdata,
  output logic                 core_gnt,
  output logic                 core_stall,
  output logic                 core_rvalid,
  output logic [REG_WIDTH-1:0] core_rdata,
  input  logic                 dbg_req,
  input  logic                 dbg_we,
  input  logic [REG_WIDTH-1:0] dbg_addr,
  input  logic [REG_WIDTH-1:0] dbg_wdata,
  output logic                 dbg_gnt,
  output logic                 dbg_rvalid,
  output logic [REG_WIDTH-1:0] dbg_rdata,
  output logic                 dmem_wr_en,
  output logic [REG_WIDTH-1:0] dmem_addr,
  output logic [REG_WIDTH-1:0] dmem_wr_data,
  input  logic [REG_WIDTH-1:0] dmem_rd_data
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  owner_t           r_owner;
  logic [CNT_W-1:0] r_starve;

  logic w_dbg_win;
  logic w_core_gnt;
  logic w_dbg_gnt;
  logic w_core_rvalid;
  logic w_dbg_rvalid;

  // Grant decision: dbg wins when core is idle or core has hit the starvation limit.
  always_comb begin
    w_dbg_win     = dbg_req & (~core_req | (r_starve == LIMIT));
    w_dbg_gnt     = ~reset & w_dbg_win;
    w_core_gnt    = ~reset & core_req & ~w_dbg_win;
    w_core_rvalid = ~reset & (r_owner == OWN_CORE);
    w_dbg_rvalid  = ~reset & (r_owner == OWN_DBG);
  end

  assign core_gnt    = w_core_gnt;
  assign dbg_gnt     = w_dbg_gnt;
  // Stall is masked in reset so every output reads 0 while reset is held.
  assign core_stall  = ~reset & core_req & ~w_core_gnt;
  assign core_rvalid = w_core_rvalid;
  assign dbg_rvalid  = w_dbg_rvalid;
  assign core_rdata  = w_core_rvalid ? dmem_rd_data : '0;
  assign dbg_rdata   = w_dbg_rvalid ? dmem_rd_data : '0;

  // DMEM command mux: zero when nobody is granted.
  always_comb begin
    dmem_wr_en   = 1'b0;
    dmem_addr    = '0;
    dmem_wr_data = '0;
    if (w_core_gnt) begin
      dmem_wr_en   = core_we;
      dmem_addr    = core_addr;
      dmem_wr_data = core_wdata;
    end else if (w_dbg_gnt) begin
      dmem_wr_en   = dbg_we;
      dmem_addr    = dbg_addr;
      dmem_wr_data = dbg_wdata;
    end
  end

  // Starvation counter and response-owner state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
      r_owner  <= OWN_NONE;
    end else begin
      if (w_dbg_gnt || !dbg_req) begin
        r_starve <= '0;
      end else if (w_core_gnt && (r_starve != LIMIT)) begin
        r_starve <= r_starve + CNT_W'(1);
      end

      if (w_core_gnt && !core_we) begin
        r_owner <= OWN_CORE;
      end else if (w_dbg_gnt && !dbg_we) begin
        r_owner <= OWN_DBG;
      end else begin
        r_owner <= OWN_NONE;
      end
    end
  end

endmodule
